// File: rtl/uart_tx_core.sv
// UART transmitter core: start bit, LSB-first data, optional even/odd parity, stop bit.
// Frame parameters are captured on accept, so input changes mid-frame cannot affect the line.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [5:0]            presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  terminal;
    logic                  parity_bit;

    assign terminal   = (cnt_q == presc_q - 6'd1);
    assign parity_bit = (^data_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    state_d   = ST_START;
                    cnt_d     = 6'd0;
                    idx_d     = '0;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    presc_d   = (PRESCALE == 6'd0) ? 6'd1 : PRESCALE;
                end
            end
            ST_START: begin
                if (terminal) begin
                    cnt_d   = 6'd0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DATA: begin
                if (terminal) begin
                    cnt_d = 6'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_PARITY: begin
                if (terminal) begin
                    cnt_d   = 6'd0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_STOP: begin
                if (terminal) begin
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is decoded from the next state so TX_OUT/BUSY change on the same edge as the FSM.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            ST_IDLE:   busy_d = 1'b0;
            ST_START:  tx_d   = 1'b0;
            ST_DATA:   tx_d   = data_d[idx_d];
            ST_PARITY: tx_d   = parity_bit;
            ST_STOP:   tx_d   = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            presc_q   <= 6'd0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: table of frames with hand-computed line sequences,
// plus hand-written sequences for reset, mid-frame disturbance and back-to-back frames.
module tb_uart_tx_core;
    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // exp holds the line bits in transmission order, first bit leftmost within nbits.
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [5:0]  presc;
        int          nbits;
        logic [10:0] exp;
    } frame_t;

    frame_t vecs[5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int cyc, input logic etx, input logic ebusy);
        checks++;
        if (TX_OUT !== etx || BUSY !== ebusy) begin
            errors++;
            $display("FAIL %s cyc=%0d TX_OUT=%b BUSY=%b expected TX_OUT=%b BUSY=%b",
                     name, cyc, TX_OUT, BUSY, etx, ebusy);
        end
    endtask

    function automatic void load(input frame_t f);
        P_DATA   = f.data;
        PAR_EN   = f.par_en;
        PAR_TYP  = f.par_typ;
        PRESCALE = f.presc;
    endfunction

    // Called right after the accepting edge. Checks up to max_cyc frame cycles; when the
    // whole frame is covered it also checks the idle cycle that must follow the stop bit.
    // With disturb set, inputs are scrambled and DATA_VALID is pulsed mid-frame.
    task automatic check_frame(input string name, input frame_t f, input int max_cyc,
                               input bit disturb);
        int p;
        int total;
        int b;
        p     = (f.presc == 6'd0) ? 1 : int'(f.presc);
        total = f.nbits * p;
        for (int i = 0; i < total && i < max_cyc; i++) begin
            b = i / p;
            check(name, i, f.exp[f.nbits - 1 - b], 1'b1);
            if (disturb && i == 10) begin
                P_DATA     = 8'h5F;
                PAR_EN     = 1'b1;
                PAR_TYP    = 1'b1;
                PRESCALE   = 6'd1;
                DATA_VALID = 1'b1;
            end
            if (disturb && i == 11) DATA_VALID = 1'b0;
            tick();
        end
        if (max_cyc >= total) check({name, "_idle"}, total, 1'b1, 1'b0);
    endtask

    task automatic send(input string name, input frame_t f, input bit disturb);
        load(f);
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        check_frame(name, f, 1000, disturb);
        $display("frame %s data=%h par_en=%b par_typ=%b prescale=%0d done", name,
                 f.data, f.par_en, f.par_typ, f.presc);
    endtask

    initial begin
        frame_t fb1;
        frame_t fe3;
        frame_t fcc;
        frame_t f2b;

        vecs[0] = '{8'hAA, 1'b1, 1'b0, 6'd1, 11, 11'b00101010101};
        vecs[1] = '{8'h05, 1'b1, 1'b1, 6'd8, 11, 11'b01010000011};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 6'd0, 11, 11'b01111000001};
        vecs[3] = '{8'h2B, 1'b1, 1'b1, 6'd3, 11, 11'b01101010011};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 6'd5, 10, 11'b00100000011};
        fb1     = '{8'hB1, 1'b0, 1'b0, 6'd4, 10, 11'b00100011011};
        fe3     = '{8'hE3, 1'b1, 1'b0, 6'd2, 11, 11'b01100011111};
        fcc     = '{8'hCC, 1'b0, 1'b0, 6'd2, 10, 11'b00001100111};
        f2b     = vecs[3];

        // Reset held with DATA_VALID high: line idle, nothing accepted.
        RST        = 1'b1;
        DATA_VALID = 1'b1;
        load(vecs[0]);
        tick();
        check("reset0", 0, 1'b1, 1'b0);
        tick();
        check("reset1", 1, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        check("post_reset", 0, 1'b1, 1'b0);

        for (int v = 0; v < 5; v++) begin
            send($sformatf("vec%0d", v), vecs[v], 1'b0);
            tick();
        end

        // Mid-frame input changes and DATA_VALID pulse are ignored.
        send("b1_disturb", fb1, 1'b1);
        load(fb1);
        tick();
        check("b1_no_queue", 0, 1'b1, 1'b0);

        // DATA_VALID held: back-to-back frames with one idle cycle between.
        load(fe3);
        DATA_VALID = 1'b1;
        tick();
        check_frame("e3_first", fe3, 1000, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        check_frame("e3_second", fe3, 1000, 1'b0);
        tick();
        check("e3_after", 0, 1'b1, 1'b0);
        $display("frame e3 back-to-back done");

        // Reset during data bit 3 abandons the frame; the next request is sent intact.
        load(fcc);
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        check_frame("cc_partial", fcc, 9, 1'b0);
        RST = 1'b1;
        tick();
        check("cc_reset", 0, 1'b1, 1'b0);
        RST = 1'b0;
        tick();
        check("cc_after_reset", 1, 1'b1, 1'b0);
        $display("frame cc aborted by reset");
        send("2b_after_reset", f2b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
